// File: rtl/mmio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_arb_pkg
// Description : Shared types and constants for the MMIO arbiter.
//               - arb_state_t: arbiter FSM states (IDLE, ACCESS, RESP)
//               - default MMIO address/data widths, also used by the
//                 MMIO peripherals behind the decoder
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_arb_pkg;

    localparam int unsigned c_MMIO_ADDR_WIDTH = 32;
    localparam int unsigned c_MMIO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

endpackage : mmio_arb_pkg
`default_nettype wire

// File: rtl/mmio_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : mmio_rr_picker
// Description : Purely combinational rotating-priority request picker.
//               The search begins at index i_start and wraps around to 0.
//               With i_start tied to 0 it is a plain lowest-index-wins
//               fixed-priority picker.
// Ports       :
//   i_req      [NUM_REQ]  request vector
//   i_start    [IDX_W]    first index to consider (must be < NUM_REQ)
//   o_grant    [NUM_REQ]  one-hot winner (all zero when no request)
//   o_grant_id [IDX_W]    winner index (0 when no request)
//   o_valid    [1]        at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_id,
    output logic               o_valid
);

    // Two ordered passes: first the indices at or above the start point,
    // then everything (which only adds the indices below the start point,
    // since a hit in the first pass already blocks the second).
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_valid    = 1'b0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (!o_valid && i_req[p] && (IDX_W'(p) >= i_start)) begin
                o_valid    = 1'b1;
                o_grant[p] = 1'b1;
                o_grant_id = IDX_W'(p);
            end
        end
        for (int p = 0; p < NUM_REQ; p++) begin
            if (!o_valid && i_req[p]) begin
                o_valid    = 1'b1;
                o_grant[p] = 1'b1;
                o_grant_id = IDX_W'(p);
            end
        end
    end

endmodule : mmio_rr_picker
`default_nettype wire

// File: rtl/mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmio_arbiter
// Description : Shares one byte-wide MMIO peripheral port between NUM_REQ
//               masters. Each transaction takes exactly three cycles:
//               IDLE (pick + latch), ACCESS (single-cycle strobe, read data
//               captured), RESP (one-cycle ack with read data).
//               All outputs decode from the state register and the latched
//               request registers; nothing is combinational from i_req*.
// Config      : `define MMIO_ARB_RR_EN -> round-robin arbitration with a
//               last-grant pointer; undefined -> fixed priority (lowest
//               index wins), no pointer register.
// Ports       :
//   i_clk            clock
//   i_rstn           asynchronous active-low reset
//   i_req            [NUM_REQ]             per-master request, held until ack
//   i_req_we         [NUM_REQ]             per-master 1 = write, 0 = read
//   i_req_addr       [NUM_REQ*ADDR_WIDTH]  per-master address (master k at k*ADDR_WIDTH)
//   i_req_wdata      [NUM_REQ*DATA_WIDTH]  per-master write data
//   o_req_ack        [NUM_REQ]             one-hot one-cycle completion pulse
//   o_req_rdata      [DATA_WIDTH]          read data, valid with ack
//   o_mmio_addr      [ADDR_WIDTH]          peripheral address
//   o_mmio_data_out  [DATA_WIDTH]          peripheral write data
//   i_mmio_data_in   [DATA_WIDTH]          peripheral read data
//   o_mmio_we        peripheral write strobe
//   o_mmio_re        peripheral read strobe
//   o_busy           high in ACCESS and RESP
//   o_grant_id       [$clog2(NUM_REQ)]     current or last granted master
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = c_MMIO_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_MMIO_DATA_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic [DATA_WIDTH-1:0]         o_req_rdata,
    output logic [ADDR_WIDTH-1:0]         o_mmio_addr,
    output logic [DATA_WIDTH-1:0]         o_mmio_data_out,
    input  logic [DATA_WIDTH-1:0]         i_mmio_data_in,
    output logic                          o_mmio_we,
    output logic                          o_mmio_re,
    output logic                          o_busy,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;

    logic [c_IDX_W-1:0]      r_grant_id;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic [c_IDX_W-1:0]      w_start;
    logic [NUM_REQ-1:0]      w_pick_oh;
    logic [c_IDX_W-1:0]      w_pick_id;
    logic                    w_pick_valid;
    logic                    w_grant_take;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    mmio_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_picker (
        .i_req      (i_req),
        .i_start    (w_start),
        .o_grant    (w_pick_oh),
        .o_grant_id (w_pick_id),
        .o_valid    (w_pick_valid)
    );

    // A grant is only taken from IDLE; requests seen in ACCESS/RESP wait.
    assign w_grant_take = (r_state == ST_IDLE) && w_pick_valid;

`ifdef MMIO_ARB_RR_EN
    logic [c_IDX_W-1:0] r_last_grant;

    // Pointer resets to the top index so the first search starts at 0.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_last_grant <= c_IDX_W'(NUM_REQ - 1);
        end else if (w_grant_take) begin
            r_last_grant <= w_pick_id;
        end
    end

    // (last + 1) mod NUM_REQ, written without '%' so non-power-of-two
    // NUM_REQ wraps correctly.
    assign w_start = (r_last_grant == c_IDX_W'(NUM_REQ - 1))
                   ? '0 : r_last_grant + c_IDX_W'(1);
`else
    assign w_start = '0;
`endif

    // ------------------------------------------------------------------
    // Request field mux for the winner
    // ------------------------------------------------------------------
    assign w_sel_we    = |(i_req_we & w_pick_oh);
    assign w_sel_addr  = i_req_addr [w_pick_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = i_req_wdata[w_pick_id*DATA_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        o_mmio_we       = 1'b0;
        o_mmio_re       = 1'b0;
        o_mmio_addr     = '0;
        o_mmio_data_out = '0;
        o_req_ack       = '0;
        o_req_rdata     = '0;
        o_busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt     = ST_RESP;
                o_busy          = 1'b1;
                o_mmio_addr     = r_addr;
                o_mmio_data_out = r_wdata;
                o_mmio_we       = r_we;
                o_mmio_re       = !r_we;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                o_busy      = 1'b1;
                o_req_ack   = NUM_REQ'(1) << r_grant_id;
                o_req_rdata = r_we ? '0 : r_rdata;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request and captured read data
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_grant_id <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_grant_take) begin
                r_grant_id <= w_pick_id;
                r_we       <= w_sel_we;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
            end
            // Peripheral read data is combinational; sample it at the end
            // of the strobe cycle.
            if ((r_state == ST_ACCESS) && !r_we) begin
                r_rdata <= i_mmio_data_in;
            end
        end
    end

    assign o_grant_id = r_grant_id;

endmodule : mmio_arbiter
`default_nettype wire

// File: tb/tb_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_arbiter
// Description : Self-checking bench for mmio_arbiter (NUM_REQ = 2,
//               32-bit address, 8-bit data). Table of single transactions
//               plus hand sequences for address change in flight, reset in
//               ACCESS, idle bus and continuous contention. Expectations
//               follow MMIO_ARB_RR_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`define CHK(nm, a, e) chk(nm, 64'(a), 64'(e))

module tb_mmio_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [1:0]  i_req;
    logic [1:0]  i_req_we;
    logic [63:0] i_req_addr;
    logic [15:0] i_req_wdata;
    logic [1:0]  o_req_ack;
    logic [7:0]  o_req_rdata;
    logic [31:0] o_mmio_addr;
    logic [7:0]  o_mmio_data_out;
    logic [7:0]  i_mmio_data_in;
    logic        o_mmio_we;
    logic        o_mmio_re;
    logic        o_busy;
    logic [0:0]  o_grant_id;

    int total = 0;
    int bad   = 0;

    mmio_arbiter dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_req           (i_req),
        .i_req_we        (i_req_we),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .o_req_ack       (o_req_ack),
        .o_req_rdata     (o_req_rdata),
        .o_mmio_addr     (o_mmio_addr),
        .o_mmio_data_out (o_mmio_data_out),
        .i_mmio_data_in  (i_mmio_data_in),
        .o_mmio_we       (o_mmio_we),
        .o_mmio_re       (o_mmio_re),
        .o_busy          (o_busy),
        .o_grant_id      (o_grant_id)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (i_rstn === 1'b1) begin
            total++;
            if ((o_mmio_we & o_mmio_re) !== 1'b0) begin
                bad++;
                $display("FAIL mon_strobe_excl: we=%0b re=%0b", o_mmio_we, o_mmio_re);
            end
            total++;
            if ((o_req_ack !== 2'b00) && (o_busy !== 1'b1)) begin
                bad++;
                $display("FAIL mon_ack_busy: ack=%0b busy=%0b", o_req_ack, o_busy);
            end
            total++;
            if ((o_req_ack === 2'b00) && (o_req_rdata !== 8'h00)) begin
                bad++;
                $display("FAIL mon_rdata_zero: rdata=%0h", o_req_rdata);
            end
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  pin;
        logic        gid;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [7:0]  exp_dout;
        logic [1:0]  exp_ack;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string s;
        s = $sformatf("v%0d", n);
        i_req          = v.req;
        i_req_we       = v.we;
        i_req_addr     = {v.a1, v.a0};
        i_req_wdata    = {v.d1, v.d0};
        i_mmio_data_in = v.pin;
        tick();
        `CHK({s, " access_we"},   o_mmio_we,       v.exp_we);
        `CHK({s, " access_re"},   o_mmio_re,       !v.exp_we);
        `CHK({s, " access_addr"}, o_mmio_addr,     v.exp_addr);
        `CHK({s, " access_dout"}, o_mmio_data_out, v.exp_dout);
        `CHK({s, " access_busy"}, o_busy,          1'b1);
        `CHK({s, " access_gid"},  o_grant_id,      v.gid);
        `CHK({s, " access_ack"},  o_req_ack,       2'b00);
        tick();
        `CHK({s, " resp_ack"},    o_req_ack,       v.exp_ack);
        `CHK({s, " resp_rdata"},  o_req_rdata,     v.exp_rd);
        `CHK({s, " resp_strobe"}, {o_mmio_we, o_mmio_re}, 2'b00);
        `CHK({s, " resp_addr"},   o_mmio_addr,     32'h0);
        i_req = 2'b00;
        tick();
        `CHK({s, " idle_ack"},    o_req_ack,       2'b00);
        `CHK({s, " idle_busy"},   o_busy,          1'b0);
        `CHK({s, " idle_rdata"},  o_req_rdata,     8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 2'b00, 32'h2000_0000, 32'h0000_0000, 8'h00, 8'h00, 8'h5A,
                    1'b0, 1'b0, 32'h2000_0000, 8'h00, 2'b01, 8'h5A};
        vecs[1] = '{2'b10, 2'b10, 32'h0000_0000, 32'h2000_0000, 8'h00, 8'hC3, 8'h77,
                    1'b1, 1'b1, 32'h2000_0000, 8'hC3, 2'b10, 8'h00};
        vecs[2] = '{2'b10, 2'b00, 32'h0000_0000, 32'h2000_0010, 8'h00, 8'h00, 8'hA5,
                    1'b1, 1'b0, 32'h2000_0010, 8'h00, 2'b10, 8'hA5};
        vecs[3] = '{2'b01, 2'b01, 32'h2000_0008, 32'h0000_0000, 8'h7E, 8'h00, 8'h33,
                    1'b0, 1'b1, 32'h2000_0008, 8'h7E, 2'b01, 8'h00};
`ifdef MMIO_ARB_RR_EN
        vecs[4] = '{2'b11, 2'b10, 32'h2000_0020, 32'h2000_0030, 8'h00, 8'h11, 8'h99,
                    1'b1, 1'b1, 32'h2000_0030, 8'h11, 2'b10, 8'h00};
`else
        vecs[4] = '{2'b11, 2'b10, 32'h2000_0020, 32'h2000_0030, 8'h00, 8'h11, 8'h99,
                    1'b0, 1'b0, 32'h2000_0020, 8'h00, 2'b01, 8'h99};
`endif
        vecs[5] = '{2'b01, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00, 8'h00, 8'hFF,
                    1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00, 2'b01, 8'hFF};

        i_rstn         = 1'b0;
        i_req          = 2'b00;
        i_req_we       = 2'b00;
        i_req_addr     = '0;
        i_req_wdata    = '0;
        i_mmio_data_in = 8'h00;

        tick();
        tick();
        `CHK("rst_ack",   o_req_ack,   2'b00);
        `CHK("rst_rdata", o_req_rdata, 8'h00);
        `CHK("rst_addr",  o_mmio_addr, 32'h0);
        `CHK("rst_dout",  o_mmio_data_out, 8'h00);
        `CHK("rst_strb",  {o_mmio_we, o_mmio_re}, 2'b00);
        `CHK("rst_busy",  o_busy,      1'b0);
        `CHK("rst_gid",   o_grant_id,  1'b0);
        i_rstn = 1'b1;
        tick();
        `CHK("post_rst_busy", o_busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        begin
            vec_t v;
            v = '{2'b10, 2'b10, 32'h0000_0000, 32'h2000_0044, 8'h00, 8'h3C, 8'h00,
                  1'b1, 1'b1, 32'h2000_0044, 8'h3C, 2'b10, 8'h00};
            run_vec(v, 6);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            `CHK("idle_gid",   o_grant_id, 1'b1);
            `CHK("idle_busy",  o_busy,     1'b0);
            `CHK("idle_strb",  {o_mmio_we, o_mmio_re}, 2'b00);
        end

        i_req          = 2'b01;
        i_req_we       = 2'b00;
        i_req_addr     = {32'h0, 32'h2000_0000};
        i_req_wdata    = 16'h0000;
        i_mmio_data_in = 8'h42;
        tick();
        i_req_addr  = {32'h0, 32'h2000_0004};
        i_req_we    = 2'b01;
        i_req_wdata = 16'h00EE;
        #1;
        `CHK("latch_addr", o_mmio_addr, 32'h2000_0000);
        `CHK("latch_re",   o_mmio_re,   1'b1);
        `CHK("latch_we",   o_mmio_we,   1'b0);
        `CHK("latch_dout", o_mmio_data_out, 8'h00);
        tick();
        `CHK("latch_ack",   o_req_ack,   2'b01);
        `CHK("latch_rdata", o_req_rdata, 8'h42);
        i_req = 2'b00;
        tick();

        i_req       = 2'b10;
        i_req_we    = 2'b10;
        i_req_addr  = {32'h2000_0000, 32'h0};
        i_req_wdata = 16'hC300;
        tick();
        `CHK("mid_we_before", o_mmio_we, 1'b1);
        i_rstn = 1'b0;
        #1;
        `CHK("mid_strb",  {o_mmio_we, o_mmio_re}, 2'b00);
        `CHK("mid_addr",  o_mmio_addr, 32'h0);
        `CHK("mid_dout",  o_mmio_data_out, 8'h00);
        `CHK("mid_busy",  o_busy, 1'b0);
        `CHK("mid_ack",   o_req_ack, 2'b00);
        `CHK("mid_rdata", o_req_rdata, 8'h00);
        `CHK("mid_gid",   o_grant_id, 1'b0);
        i_req = 2'b00;
        tick();
        i_rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            `CHK("mid_after_ack",  o_req_ack, 2'b00);
            `CHK("mid_after_busy", o_busy, 1'b0);
        end

        i_req          = 2'b11;
        i_req_we       = 2'b00;
        i_req_addr     = {32'h2000_0200, 32'h2000_0100};
        i_req_wdata    = 16'h0000;
        i_mmio_data_in = 8'h00;
        for (int t = 0; t < 4; t++) begin
            logic [1:0]  eack;
            logic [31:0] eaddr;
`ifdef MMIO_ARB_RR_EN
            eack = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            eack = 2'b01;
`endif
            eaddr = (eack == 2'b01) ? 32'h2000_0100 : 32'h2000_0200;
            tick();
            `CHK("cont_re",   o_mmio_re, 1'b1);
            `CHK("cont_addr", o_mmio_addr, eaddr);
            tick();
            `CHK("cont_ack",  o_req_ack, eack);
            tick();
            `CHK("cont_idle_ack", o_req_ack, 2'b00);
        end
        i_req = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mmio_arbiter

`undef CHK
`default_nettype wire
